// File: rtl/comm_par_pkg.sv
// Shared types and constants for the commParalel bus master.
// Widths of the nibble bus, the host byte and the slave address space.
package comm_par_pkg;

   localparam int NIB_W  = 4;
   localparam int BYTE_W = 8;
   localparam int ADDR_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_STROBE = 3'd2,
      ST_HOLD   = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   // Slave address of a nibble: base for the low nibble, base+1 (wrapping) for the high one.
   function automatic logic [ADDR_W-1:0] nib_addr(input logic [ADDR_W-1:0] base,
                                                  input logic              nib);
      return base + {{(ADDR_W-1){1'b0}}, nib};
   endfunction

endpackage

// File: rtl/comm_par_if.sv
// Host request/response handshake plus the parallel pins of the commParalel slave.
// The master modport is the bus master; the slave modport is the host/pin side around it.
interface comm_par_if;
   import comm_par_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [BYTE_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [BYTE_W-1:0] rsp_rdata;
   logic [ADDR_W-1:0] bus_addr;
   logic [NIB_W-1:0]  bus_wdata;
   logic              bus_wdata_oe;
   logic [NIB_W-1:0]  bus_rdata;
   logic              bus_write;
   logic              bus_read;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, bus_rdata,
      output req_ready, rsp_valid, rsp_rdata,
      output bus_addr, bus_wdata, bus_wdata_oe, bus_write, bus_read
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, bus_rdata,
      input  req_ready, rsp_valid, rsp_rdata,
      input  bus_addr, bus_wdata, bus_wdata_oe, bus_write, bus_read
   );

endinterface

// File: rtl/comm_par_timer.sv
// Loadable down-counter timing one bus phase; done is high in the last cycle of the phase.
// A start in that same cycle chains straight into the next phase.
module comm_par_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] cnt_r;
   logic             run_r;

   // Count the loaded number of cycles down to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= '0;
         run_r <= 1'b0;
      end else if (start) begin
         cnt_r <= load_val - {{(CNT_W-1){1'b0}}, 1'b1};
         run_r <= 1'b1;
      end else if (run_r) begin
         if (cnt_r == '0) begin
            run_r <= 1'b0;
         end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign done = run_r && (cnt_r == '0);

endmodule

// File: rtl/comm_par_master.sv
// Bus master for the commParalel slave: each host byte becomes two timed nibble cycles,
// low nibble at addr and high nibble at addr+1, with registered pin outputs.
module comm_par_master
   import comm_par_pkg::*;
#(
   parameter int SETUP_CYC  = 2,
   parameter int STROBE_CYC = 4,
   parameter int HOLD_CYC   = 2,
   parameter int CNT_W      = 4
) (
   input logic         clk,
   input logic         rst,
   comm_par_if.master  cp
);

   localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC);
   localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC);
   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC);

   state_e            state_r;
   logic              wr_r;
   logic [ADDR_W-1:0] addr_r;
   logic [BYTE_W-1:0] wdata_r;
   logic [BYTE_W-1:0] rdata_r;
   logic              nib_r;
   logic              req_ready_r;
   logic              rsp_valid_r;
   logic [BYTE_W-1:0] rsp_rdata_r;
   logic [ADDR_W-1:0] bus_addr_r;
   logic [NIB_W-1:0]  bus_wdata_r;
   logic              bus_oe_r;
   logic              bus_write_r;
   logic              bus_read_r;

   logic              accept_s;
   logic              tmr_start_s;
   logic [CNT_W-1:0]  tmr_load_s;
   logic              tmr_done_s;

   assign accept_s = (state_r == ST_IDLE) && req_ready_r && cp.req_valid;

   // Restart the phase timer on every phase entry with that phase's length.
   always_comb begin
      tmr_start_s = 1'b0;
      tmr_load_s  = SETUP_LD;
      case (state_r)
         ST_IDLE: begin
            tmr_start_s = accept_s;
            tmr_load_s  = SETUP_LD;
         end
         ST_SETUP: begin
            tmr_start_s = tmr_done_s;
            tmr_load_s  = STROBE_LD;
         end
         ST_STROBE: begin
            tmr_start_s = tmr_done_s;
            tmr_load_s  = HOLD_LD;
         end
         ST_HOLD: begin
            tmr_start_s = tmr_done_s && !nib_r;
            tmr_load_s  = SETUP_LD;
         end
         default: begin
            tmr_start_s = 1'b0;
            tmr_load_s  = SETUP_LD;
         end
      endcase
   end

   comm_par_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .start    (tmr_start_s),
      .load_val (tmr_load_s),
      .done     (tmr_done_s)
   );

   // Transaction sequencer; every pin output is registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         wr_r        <= 1'b0;
         addr_r      <= '0;
         wdata_r     <= '0;
         rdata_r     <= '0;
         nib_r       <= 1'b0;
         req_ready_r <= 1'b1;
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= '0;
         bus_addr_r  <= '0;
         bus_wdata_r <= '0;
         bus_oe_r    <= 1'b0;
         bus_write_r <= 1'b0;
         bus_read_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               rsp_valid_r <= 1'b0;
               if (accept_s) begin
                  wr_r        <= cp.req_write;
                  addr_r      <= cp.req_addr;
                  wdata_r     <= cp.req_wdata;
                  nib_r       <= 1'b0;
                  bus_addr_r  <= cp.req_addr;
                  bus_wdata_r <= cp.req_wdata[NIB_W-1:0];
                  bus_oe_r    <= cp.req_write;
                  req_ready_r <= 1'b0;
                  state_r     <= ST_SETUP;
               end else begin
                  req_ready_r <= 1'b1;
               end
            end
            ST_SETUP: begin
               if (tmr_done_s) begin
                  bus_write_r <= wr_r;
                  bus_read_r  <= ~wr_r;
                  state_r     <= ST_STROBE;
               end
            end
            ST_STROBE: begin
               if (tmr_done_s) begin
                  if (!wr_r) begin
                     rdata_r[{nib_r, 2'b00} +: NIB_W] <= cp.bus_rdata;
                  end
                  bus_write_r <= 1'b0;
                  bus_read_r  <= 1'b0;
                  state_r     <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               // Address/data may only move here, after the hold window, never under a strobe.
               if (tmr_done_s) begin
                  if (!nib_r) begin
                     nib_r       <= 1'b1;
                     bus_addr_r  <= nib_addr(addr_r, 1'b1);
                     bus_wdata_r <= wdata_r[BYTE_W-1:NIB_W];
                     state_r     <= ST_SETUP;
                  end else begin
                     rsp_valid_r <= 1'b1;
                     if (!wr_r) begin
                        rsp_rdata_r <= rdata_r;
                     end
                     bus_oe_r    <= 1'b0;
                     state_r     <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               rsp_valid_r <= 1'b0;
               req_ready_r <= 1'b1;
               state_r     <= ST_IDLE;
            end
            default: begin
               bus_write_r <= 1'b0;
               bus_read_r  <= 1'b0;
               bus_oe_r    <= 1'b0;
               rsp_valid_r <= 1'b0;
               req_ready_r <= 1'b1;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   assign cp.req_ready    = req_ready_r;
   assign cp.rsp_valid    = rsp_valid_r;
   assign cp.rsp_rdata    = rsp_rdata_r;
   assign cp.bus_addr     = bus_addr_r;
   assign cp.bus_wdata    = bus_wdata_r;
   assign cp.bus_wdata_oe = bus_oe_r;
   assign cp.bus_write    = bus_write_r;
   assign cp.bus_read     = bus_read_r;

endmodule

// File: tb/tb_comm_par_master.sv
// Directed bench for comm_par_master: a small slave model answers reads, a pin monitor
// records strobe pulses, and every expectation below is a hand-computed constant.
module tb_comm_par_master;
   import comm_par_pkg::*;

   localparam int SETUP_CYC  = 2;
   localparam int STROBE_CYC = 4;
   localparam int HOLD_CYC   = 2;
   localparam int EXP_LAT    = 18;  // accept cycle counted as cycle 1

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   comm_par_if cp ();

   comm_par_master #(
      .SETUP_CYC  (SETUP_CYC),
      .STROBE_CYC (STROBE_CYC),
      .HOLD_CYC   (HOLD_CYC),
      .CNT_W      (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .cp  (cp)
   );

   function automatic logic [3:0] slave_nib(input logic [7:0] a);
      if (a == 8'h20) return 4'h3;
      else if (a == 8'h21) return 4'hC;
      else return a[3:0] + 4'h1;
   endfunction

   always_comb cp.bus_rdata = slave_nib(cp.bus_addr);

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Pin monitor: strobe pulses, overlap and stability violations, responses, accepts.
   logic       w_prev = 1'b0;
   logic       r_prev = 1'b0;
   logic [7:0] prev_addr = 8'h00;
   logic [3:0] prev_wd = 4'h0;
   int         w_len = 0;
   int         r_len = 0;
   int         overlap_viol = 0;
   int         stable_viol = 0;
   int         oe_hi_cnt = 0;
   int         rsp_cnt = 0;
   int         acc_cnt = 0;
   logic [7:0] pw_addr[$];
   logic [3:0] pw_data[$];
   logic       pw_oe[$];
   int         pw_len[$];
   logic [7:0] pr_addr[$];
   int         pr_len[$];

   always @(negedge clk) begin
      if (cp.bus_write && cp.bus_read) overlap_viol <= overlap_viol + 1;
      if ((cp.bus_write || cp.bus_read) && (cp.bus_addr !== prev_addr || cp.bus_wdata !== prev_wd))
         stable_viol <= stable_viol + 1;
      if (cp.bus_wdata_oe) oe_hi_cnt <= oe_hi_cnt + 1;
      if (cp.rsp_valid) rsp_cnt <= rsp_cnt + 1;
      if (cp.bus_write && !w_prev) begin
         pw_addr.push_back(cp.bus_addr);
         pw_data.push_back(cp.bus_wdata);
         pw_oe.push_back(cp.bus_wdata_oe);
      end
      if (cp.bus_write) w_len <= w_len + 1;
      else begin
         if (w_prev) pw_len.push_back(w_len);
         w_len <= 0;
      end
      if (cp.bus_read && !r_prev) pr_addr.push_back(cp.bus_addr);
      if (cp.bus_read) r_len <= r_len + 1;
      else begin
         if (r_prev) pr_len.push_back(r_len);
         r_len <= 0;
      end
      w_prev    <= cp.bus_write;
      r_prev    <= cp.bus_read;
      prev_addr <= cp.bus_addr;
      prev_wd   <= cp.bus_wdata;
   end

   always @(posedge clk) begin
      if (!rst && cp.req_valid && cp.req_ready) acc_cnt <= acc_cnt + 1;
   end

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic clear_mon();
      pw_addr.delete(); pw_data.delete(); pw_oe.delete(); pw_len.delete();
      pr_addr.delete(); pr_len.delete();
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_ready"}, 32'(cp.req_ready),    32'h1);
      check({tag, "_rspv"},  32'(cp.rsp_valid),    32'h0);
      check({tag, "_rdata"}, 32'(cp.rsp_rdata),    32'h0);
      check({tag, "_addr"},  32'(cp.bus_addr),     32'h0);
      check({tag, "_wdata"}, 32'(cp.bus_wdata),    32'h0);
      check({tag, "_oe"},    32'(cp.bus_wdata_oe), 32'h0);
      check({tag, "_bw"},    32'(cp.bus_write),    32'h0);
      check({tag, "_br"},    32'(cp.bus_read),     32'h0);
   endtask

   // Wait, bounded, for rsp_valid; k enters as the current cycle number of the transaction.
   task automatic wait_rsp(input string tag, input int k0);
      int  k;
      bit  seen;
      k = k0;
      seen = 1'b0;
      while (!seen && k < 60) begin
         if (cp.rsp_valid) seen = 1'b1;
         else begin
            step();
            k++;
         end
      end
      check({tag, "_rsp_cycle"}, 32'(k), 32'(EXP_LAT));
   endtask

   task automatic run_txn(input string tag, input logic wr, input logic [7:0] a, input logic [7:0] d);
      int k;
      cp.req_valid = 1'b1;
      cp.req_write = wr;
      cp.req_addr  = a;
      cp.req_wdata = d;
      k = 0;
      while (!cp.req_ready && k < 50) begin
         step();
         k++;
      end
      check({tag, "_ready"}, 32'(cp.req_ready), 32'h1);
      step();
      cp.req_valid = 1'b0;
      check({tag, "_busy"}, 32'(cp.req_ready), 32'h0);
      wait_rsp(tag, 2);
      step();
      check({tag, "_rsp_1cyc"}, 32'(cp.rsp_valid), 32'h0);
      check({tag, "_idle"}, 32'(cp.req_ready), 32'h1);
   endtask

   initial begin
      int k;
      int acc0;
      int rsp0;
      int oe0;
      cp.req_valid = 1'b0;
      cp.req_write = 1'b0;
      cp.req_addr  = 8'h00;
      cp.req_wdata = 8'h00;
      rst = 1'b1;
      repeat (3) step();
      check_reset("rst");
      rst = 1'b0;
      step();

      // Write 0xA5 to 0x10: 0x5 at 0x10, then 0xA at 0x11.
      clear_mon();
      run_txn("wr10", 1'b1, 8'h10, 8'hA5);
      check("wr10_npulse", 32'(pw_len.size()), 32'h2);
      if (pw_len.size() == 2 && pw_addr.size() == 2) begin
         check("wr10_a0",   32'(pw_addr[0]), 32'h10);
         check("wr10_d0",   32'(pw_data[0]), 32'h5);
         check("wr10_len0", 32'(pw_len[0]),  32'(STROBE_CYC));
         check("wr10_oe0",  32'(pw_oe[0]),   32'h1);
         check("wr10_a1",   32'(pw_addr[1]), 32'h11);
         check("wr10_d1",   32'(pw_data[1]), 32'hA);
         check("wr10_len1", 32'(pw_len[1]),  32'(STROBE_CYC));
      end
      check("wr10_noread", 32'(pr_addr.size()), 32'h0);
      check("wr10_rdata_stale", 32'(cp.rsp_rdata), 32'h0);
      check("wr10_oe_off", 32'(cp.bus_wdata_oe), 32'h0);

      // Read at 0x20: slave gives 0x3 then 0xC.
      clear_mon();
      oe0 = oe_hi_cnt;
      run_txn("rd20", 1'b0, 8'h20, 8'h00);
      check("rd20_rdata", 32'(cp.rsp_rdata), 32'hC3);
      check("rd20_npulse", 32'(pr_len.size()), 32'h2);
      if (pr_len.size() == 2 && pr_addr.size() == 2) begin
         check("rd20_a0",   32'(pr_addr[0]), 32'h20);
         check("rd20_a1",   32'(pr_addr[1]), 32'h21);
         check("rd20_len0", 32'(pr_len[0]),  32'(STROBE_CYC));
         check("rd20_len1", 32'(pr_len[1]),  32'(STROBE_CYC));
      end
      check("rd20_oe_never", 32'(oe_hi_cnt - oe0), 32'h0);
      check("rd20_nowrite", 32'(pw_addr.size()), 32'h0);

      // Write 0x12 to 0xFF: high nibble wraps to address 0x00.
      clear_mon();
      run_txn("wrff", 1'b1, 8'hFF, 8'h12);
      check("wrff_npulse", 32'(pw_addr.size()), 32'h2);
      if (pw_addr.size() == 2) begin
         check("wrff_a0", 32'(pw_addr[0]), 32'hFF);
         check("wrff_d0", 32'(pw_data[0]), 32'h2);
         check("wrff_a1", 32'(pw_addr[1]), 32'h00);
         check("wrff_d1", 32'(pw_data[1]), 32'h1);
      end
      check("wrff_rdata_kept", 32'(cp.rsp_rdata), 32'hC3);

      // Held request: write 0x3C@0x40, then read @0x50 waits (slave: 0x1,0x2 -> 0x21).
      clear_mon();
      acc0 = acc_cnt;
      rsp0 = rsp_cnt;
      cp.req_valid = 1'b1;
      cp.req_write = 1'b1;
      cp.req_addr  = 8'h40;
      cp.req_wdata = 8'h3C;
      step();
      cp.req_write = 1'b0;
      cp.req_addr  = 8'h50;
      cp.req_wdata = 8'h00;
      check("b2b_busy", 32'(cp.req_ready), 32'h0);
      k = 2;
      while (!cp.req_ready && k < 60) begin
         step();
         k++;
      end
      check("b2b_reaccept_cycle", 32'(k), 32'(EXP_LAT + 1));
      step();
      cp.req_valid = 1'b0;
      wait_rsp("b2b_rd", 2);
      check("b2b_rdata", 32'(cp.rsp_rdata), 32'h21);
      step();
      step();
      check("b2b_accepts", 32'(acc_cnt - acc0), 32'h2);
      check("b2b_rsps", 32'(rsp_cnt - rsp0), 32'h2);
      check("b2b_nwr", 32'(pw_addr.size()), 32'h2);
      check("b2b_nrd", 32'(pr_addr.size()), 32'h2);
      if (pw_addr.size() == 2 && pr_addr.size() == 2) begin
         check("b2b_wa0", 32'(pw_addr[0]), 32'h40);
         check("b2b_wd0", 32'(pw_data[0]), 32'hC);
         check("b2b_wa1", 32'(pw_addr[1]), 32'h41);
         check("b2b_wd1", 32'(pw_data[1]), 32'h3);
         check("b2b_ra0", 32'(pr_addr[0]), 32'h50);
         check("b2b_ra1", 32'(pr_addr[1]), 32'h51);
      end

      // Reset during the first strobe cycle of a write.
      cp.req_valid = 1'b1;
      cp.req_write = 1'b1;
      cp.req_addr  = 8'h60;
      cp.req_wdata = 8'h77;
      step();
      cp.req_valid = 1'b0;
      k = 0;
      while (!cp.bus_write && k < 20) begin
         step();
         k++;
      end
      check("mid_strobe_seen", 32'(cp.bus_write), 32'h1);
      rsp0 = rsp_cnt;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset("mid_rst");
      repeat (25) step();
      check("mid_no_rsp", 32'(rsp_cnt - rsp0), 32'h0);
      check("mid_idle", 32'(cp.req_ready), 32'h1);

      check("never_both_strobes", 32'(overlap_viol), 32'h0);
      check("stable_under_strobe", 32'(stable_viol), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
